// File: rtl/data_queue_credits_src.sv
// Credit-gated AXI4S source: forwards beats toward a credit-counting sink queue
// through a one-beat registered output slot, spending one credit per accepted beat.
module data_queue_credits_src #(
  parameter int CRED_MAX  = 512,
  parameter int CRED_BITS = $clog2(CRED_MAX + 1),
  parameter int DATA_BITS = 512
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   credit_ret,
  output logic [CRED_BITS-1:0]   credits,
  output logic                   xfer,
  output logic                   cred_err
);

  localparam logic [CRED_BITS-1:0] LP_CRED_MAX = CRED_BITS'(CRED_MAX);
  localparam logic [CRED_BITS-1:0] LP_ONE      = CRED_BITS'(1);

  logic                   r_vld;
  logic [DATA_BITS-1:0]   r_data;
  logic [DATA_BITS/8-1:0] r_keep;
  logic                   r_last;
  logic [CRED_BITS-1:0]   r_credits;
  logic                   r_xfer;
  logic                   r_cred_err;

  logic                   w_slot_free;
  logic                   w_acc;
  logic [CRED_BITS-1:0]   w_cred_nxt;
  logic                   w_err_set;

  // Slot is free when empty or when its beat leaves this cycle.
  assign w_slot_free   = !r_vld || m_axis_tready;
  assign s_axis_tready = (r_credits != '0) && w_slot_free;
  assign w_acc         = s_axis_tvalid && s_axis_tready;

  always_comb begin
    w_cred_nxt = r_credits;
    w_err_set  = 1'b0;
    if (w_acc && !credit_ret) begin
      w_cred_nxt = r_credits - LP_ONE;
    end else if (!w_acc && credit_ret) begin
      if (r_credits == LP_CRED_MAX) w_err_set = 1'b1;
      else                          w_cred_nxt = r_credits + LP_ONE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_vld      <= 1'b0;
      r_data     <= '0;
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_credits  <= LP_CRED_MAX;
      r_xfer     <= 1'b0;
      r_cred_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_vld  <= 1'b1;
        r_data <= s_axis_tdata;
        r_keep <= s_axis_tkeep;
        r_last <= s_axis_tlast;
      end else if (m_axis_tready) begin
        r_vld  <= 1'b0;
      end
      r_credits  <= w_cred_nxt;
      r_xfer     <= w_acc;
      r_cred_err <= r_cred_err || w_err_set;
    end
  end

  assign m_axis_tvalid = r_vld;
  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = r_keep;
  assign m_axis_tlast  = r_last;
  assign credits       = r_credits;
  assign xfer          = r_xfer;
  assign cred_err      = r_cred_err;

endmodule

// File: tb/tb_data_queue_credits_src.sv
// Bench for data_queue_credits_src: fixed vector table, directed corner sequences
// and random traffic against a queue-based credit model.
module tb_data_queue_credits_src;

  localparam int CRED_MAX  = 512;
  localparam int CRED_BITS = $clog2(CRED_MAX + 1);
  localparam int DATA_BITS = 32;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b1;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready;
  logic [31:0]          s_tdata = '0;
  logic [3:0]           s_tkeep = '0;
  logic                 s_tlast = 1'b0;
  logic                 m_tvalid;
  logic                 m_tready = 1'b0;
  logic [31:0]          m_tdata;
  logic [3:0]           m_tkeep;
  logic                 m_tlast;
  logic                 credit_ret = 1'b0;
  logic [CRED_BITS-1:0] credits;
  logic                 xfer;
  logic                 cred_err;

  data_queue_credits_src #(
    .CRED_MAX (CRED_MAX),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .aclk         (clk),
    .aresetn      (aresetn),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .credit_ret   (credit_ret),
    .credits      (credits),
    .xfer         (xfer),
    .cred_err     (cred_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue standing in for the output slot, plus plain counters.
  logic [36:0] mdl_slot[$];
  int          mdl_cred = CRED_MAX;
  logic        mdl_err  = 1'b0;
  logic        mdl_xfer = 1'b0;

  int dut_acc_cnt  = 0;
  int dut_xfer_cnt = 0;
  int a5_seen      = 0;

  typedef struct {
    logic        tv;
    logic [31:0] d;
    logic        l;
    logic        mr;
    logic        ret;
    logic        exp_tready;
    logic        exp_tvalid;
    logic [31:0] exp_tdata;
    int          exp_cred;
    logic        exp_xfer;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic tv, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic mr, input logic ret);
    logic exp_tready, acc, mhs;
    s_tvalid = tv; s_tdata = d; s_tkeep = k; s_tlast = l;
    m_tready = mr; credit_ret = ret;
    #1;
    exp_tready = (mdl_cred != 0) && ((mdl_slot.size() == 0) || mr);
    check("s_tready", 64'(s_tready), 64'(exp_tready));
    if (s_tvalid && s_tready) dut_acc_cnt++;
    if (m_tvalid && m_tready && m_tdata == 32'hA5A5A5A5) a5_seen++;
    acc = tv && exp_tready;
    mhs = (mdl_slot.size() != 0) && mr;
    if (mhs) void'(mdl_slot.pop_front());
    if (acc) mdl_slot.push_back({l, k, d});
    if (acc && !ret) mdl_cred = mdl_cred - 1;
    else if (ret && !acc) begin
      if (mdl_cred == CRED_MAX) mdl_err = 1'b1;
      else mdl_cred = mdl_cred + 1;
    end
    mdl_xfer = acc;
    @(posedge clk); #1;
    check("m_tvalid", 64'(m_tvalid), 64'(mdl_slot.size() != 0));
    if (mdl_slot.size() != 0)
      check("m_beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(mdl_slot[0]));
    check("credits", 64'(credits), 64'(mdl_cred));
    check("xfer", 64'(xfer), 64'(mdl_xfer));
    check("cred_err", 64'(cred_err), 64'(mdl_err));
    if (xfer) dut_xfer_cnt++;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0; credit_ret = 1'b0; m_tready = 1'b0;
    #2; aresetn = 1'b0; #1;
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tdata", 64'({m_tlast, m_tkeep, m_tdata}), 64'(0));
    check("rst_credits", 64'(credits), 64'(CRED_MAX));
    check("rst_xfer", 64'(xfer), 64'(0));
    check("rst_cred_err", 64'(cred_err), 64'(0));
    mdl_slot.delete(); mdl_cred = CRED_MAX; mdl_err = 1'b0; mdl_xfer = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
  endtask

  initial begin
    //             tv  data          last mr  ret  tready tvalid tdata         cred xfer
    vecs[0] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 511, 1'b1};
    vecs[1] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 511, 1'b0};
    vecs[2] = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22222222, 510, 1'b1};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        511, 1'b0};
    vecs[4] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333, 511, 1'b1};
    vecs[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 511, 1'b0};

    @(posedge clk); #1;
    do_reset();

    // Vector table
    for (int i = 0; i < 6; i++) begin
      s_tvalid = vecs[i].tv; m_tready = vecs[i].mr; #1;
      check("tbl_tready", 64'(s_tready), 64'(vecs[i].exp_tready));
      cycle(vecs[i].tv, vecs[i].d, 4'hF, vecs[i].l, vecs[i].mr, vecs[i].ret);
      check("tbl_tvalid", 64'(m_tvalid), 64'(vecs[i].exp_tvalid));
      if (vecs[i].exp_tvalid) check("tbl_tdata", 64'(m_tdata), 64'(vecs[i].exp_tdata));
      check("tbl_credits", 64'(credits), 64'(vecs[i].exp_cred));
      check("tbl_xfer", 64'(xfer), 64'(vecs[i].exp_xfer));
    end

    // Drain all credits with incrementing data
    do_reset();
    dut_acc_cnt = 0;
    for (int i = 0; i < 520; i++) cycle(1'b1, 32'(i), 4'hF, 1'b0, 1'b1, 1'b0);
    check("drain_beats", 64'(dut_acc_cnt), 64'(512));
    check("drain_credits", 64'(credits), 64'(0));

    // Single credit return at zero
    dut_acc_cnt = 0;
    cycle(1'b1, 32'hBEEF0001, 4'hF, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'hBEEF0002, 4'hF, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hBEEF0003, 4'hF, 1'b0, 1'b1, 1'b0);
    check("ret1_beats", 64'(dut_acc_cnt), 64'(1));
    check("ret1_credits", 64'(credits), 64'(0));

    // Credits at 5 with simultaneous accept and return
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    dut_xfer_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h5000 + 32'(i), 4'h3, 1'b0, 1'b1, 1'b1);
    check("both_credits", 64'(credits), 64'(5));
    check("both_xfer_cnt", 64'(dut_xfer_cnt), 64'(10));

    // Long stall with one beat held
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    a5_seen = 0;
    cycle(1'b1, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 4'h1, 1'b0, 1'b0, 1'b0);
    check("stall_tdata", 64'({m_tlast, m_tdata}), {31'h0, 1'b1, 32'hA5A5A5A5});
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("stall_once", 64'(a5_seen), 64'(1));

    // Overflowing credit return is sticky
    do_reset();
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("ovf_credits", 64'(credits), 64'(CRED_MAX));
    check("ovf_err", 64'(cred_err), 64'(1));
    random_cycles(30);
    check("ovf_err_sticky", 64'(cred_err), 64'(1));

    // Random traffic
    do_reset();
    random_cycles(2000);

    // Reset mid-stream with slot full at 300 credits
    do_reset();
    for (int i = 0; i < 212; i++) cycle(1'b1, 32'h7000 + 32'(i), 4'hF, 1'b0, 1'b1, 1'b0);
    check("mid_credits", 64'(credits), 64'(300));
    check("mid_full", 64'(m_tvalid), 64'(1));
    do_reset();
    random_cycles(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_queue_credits_src.md
Name: data_queue_credits_src

Overview:
- Transmit-side companion to the credit-counting data queue sink in the MMU data path.
- Holds a credit counter sized to the sink FIFO depth and forwards AXI4S beats only while credits remain.
- Regains one credit per credit-return pulse from the sink side, so the sink FIFO never overflows.
- Output is fully registered: one-beat output slice, no combinational path from m_axis.tready or credit state to the output data.

Parameters:
- CRED_MAX, 512: sink FIFO depth; reset and maximum credit count.
- CRED_BITS, $clog2(CRED_MAX+1): credit counter width.
- DATA_BITS, 512: AXI4S tdata width; tkeep is DATA_BITS/8.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous assert, active-low; deasserted synchronously to aclk by the system.
- s_axis  AXI4S.s  DATA_BITS  upstream data (tvalid, tready, tdata, tkeep, tlast).
- m_axis  AXI4S.m  DATA_BITS  data toward the sink queue.
- credit_ret  in  1  one pulse per beat freed in the sink; one credit per cycle high.
- credits  out  CRED_BITS  current credit count.
- xfer  out  1  pulse when a beat is accepted on s_axis.
- cred_err  out  1  sticky flag: credit return while the count is already CRED_MAX.

Behaviour:
- Reset (aresetn low, async):
  - credits = CRED_MAX.
  - Output slot empty, so m_axis.tvalid = 0.
  - m_axis.tdata, tkeep and tlast = 0.
  - xfer = 0 and cred_err = 0.
  - Reset mid-transfer drops any beat held in the output slot. No recovery of partial packets.
- Output slot: one register stage holding tdata, tkeep, tlast and a valid bit.
  - m_axis.tvalid = slot valid.
  - Slot "free" = empty OR (m_axis.tvalid AND m_axis.tready).
- Upstream handshake:
  - s_axis.tready = (credits != 0) AND slot free.
  - Beat accepted (acc) = s_axis.tvalid AND s_axis.tready.
  - On acc the slot loads the s_axis fields and valid = 1, all on the next edge.
  - If m_axis takes the held beat and no acc occurs in the same cycle, valid = 0.
  - Latency is 1 cycle from s_axis acceptance to m_axis.tvalid.
  - Sustained throughput is 1 beat/cycle while credits are non-zero and m_axis.tready is high.
- Credit arithmetic, registered:
  - acc only: credits - 1.
  - credit_ret only: credits + 1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Empty boundary:
  - Credits are debited at s_axis acceptance, before the beat leaves the slot.
  - At credits = 0, s_axis.tready = 0. A held beat still drains on m_axis.
  - A credit_ret at credits = 0 lets tready rise the next cycle, never the same cycle.
  - credit_ret and acc cannot coincide at 0, because tready is 0 there.
- Full boundary:
  - credit_ret with credits = CRED_MAX and no acc in that cycle: count saturates at CRED_MAX and cred_err is set.
  - cred_err stays set until reset.
- xfer:
  - Registered copy of acc, so it pulses 1 cycle after acceptance, aligned with the slot load.
- Stalls:
  - While m_axis.tvalid = 1 and m_axis.tready = 0, m_axis.tdata, tkeep and tlast hold stable (AXI4S rule). tvalid never drops without a handshake.
- tlast and tkeep pass through unmodified. The block has no packet awareness; credits are per beat.

Test Plan:
1. Reset, s_axis.tvalid = 1 with tdata = incrementing, m_axis.tready = 1, no credit_ret:
   - Exactly 512 beats appear on m_axis, in order, 1 cycle behind acceptance.
   - credits reaches 0 and s_axis.tready = 0 thereafter.
2. From credits = 0, one credit_ret pulse:
   - s_axis.tready = 1 on the next cycle only.
   - Exactly one beat is accepted and credits returns to 0.
3. Credits = 5 with acc and credit_ret both high for 10 cycles:
   - credits stays at 5 throughout.
   - 10 beats are delivered and xfer is high for 10 cycles.
4. m_axis.tready held low for 20 cycles with a beat held, tdata = 0xA5.., tlast = 1:
   - m_axis fields stay stable and s_axis.tready = 0.
   - Once tready rises, the beat transfers once and is never duplicated.
5. After reset, one credit_ret pulse:
   - credits stays at 512 and cred_err = 1.
   - cred_err stays set through later traffic until aresetn is pulsed.
6. aresetn asserted mid-stream with the slot full and credits = 300:
   - Asynchronously m_axis.tvalid = 0, credits = 512 and xfer = 0.
   - Traffic resumes normally after release.
